mcpu_alu_arbiter: RTL
=====================

Name: mcpu_alu_arbiter

Overview:
- Shares one combinational MCPU ALU (4 ops: AND/OR/XOR/ADD) between NREQ requesters using round-robin arbitration.
- Latches the granted requester's opcode and operands, drives the ALU, and registers result and overflow.
- Returns the result with a one-cycle ack to the granted requester.
- Sits between the MCPU control units and the single ALU instance.

Parameters:
- CMD_SIZE, 2, opcode width (00 AND, 01 OR, 10 XOR, 11 ADD)
- WORD_SIZE, 2, operand/result width
- NREQ, 4, number of requesters
- CNT_SIZE, 8, width of completed-operation counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  level request per requester
- op_in  in  NREQ*CMD_SIZE  packed opcodes; requester i at [i*CMD_SIZE +: CMD_SIZE]
- a_in  in  NREQ*WORD_SIZE  packed operand A per requester
- b_in  in  NREQ*WORD_SIZE  packed operand B per requester
- ack  out  NREQ  one-hot, one-cycle completion pulse
- res_out  out  WORD_SIZE  registered result; valid while any ack bit is high
- ovf_out  out  1  registered overflow; valid with ack
- busy  out  1  high in EXEC and RESP
- grant_id  out  log2(NREQ)  index of the requester being served
- ops_done  out  CNT_SIZE  completed-operation count, wraps modulo 2^CNT_SIZE
- alu_opcode  out  CMD_SIZE  to ALU opcode
- alu_r1  out  WORD_SIZE  to ALU operand 1
- alu_r2  out  WORD_SIZE  to ALU operand 2
- alu_out  in  WORD_SIZE  from ALU result
- alu_overflow  in  1  from ALU OVERFLOW

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state=IDLE; ack, res_out, ovf_out, busy, grant_id, ops_done, alu_opcode, alu_r1, alu_r2 all 0; priority pointer = 0, so requester 0 is first.
- FSM states: IDLE, EXEC, RESP. All outputs are registered.
- IDLE:
  - If req is 0, stay in IDLE.
  - Otherwise pick the first set req bit scanning ptr, ptr+1, … modulo NREQ.
  - Latch grant_id and that requester's op/a/b into alu_opcode/alu_r1/alu_r2; go to EXEC.
- EXEC:
  - ALU settles for one full cycle.
  - At the end of the cycle, capture res_out <= alu_out.
  - Capture ovf_out <= alu_overflow only when alu_opcode == 2'b11; otherwise ovf_out <= 0.
  - Set ack[grant_id] <= 1 and go to RESP.
- RESP:
  - ack is high for exactly this one cycle; res_out and ovf_out are stable.
  - Increment ops_done (wraps); set ptr <= grant_id+1 modulo NREQ; clear ack; go to IDLE.
- Latency and throughput:
  - req high at edge n (IDLE) -> ack high during cycle n+2.
  - Maximum throughput is one operation per 3 cycles.
- Operand sampling:
  - Operands are sampled only at the grant edge.
  - Changes to op_in/a_in/b_in or req after grant do not affect the in-flight operation.
- Handshake:
  - req is level-sensitive. A requester wanting one operation deasserts req in the cycle it sees ack.
  - A req still high in the following IDLE cycle is treated as a new request.
  - Because ptr has advanced past it, other pending requesters win first (no starvation).
- Deassertion before grant: req dropped before being granted withdraws the request; no ack is generated.
- Arithmetic:
  - The ALU does the arithmetic. res_out is exactly WORD_SIZE bits of alu_out (ADD wraps).
  - The arbiter performs no arithmetic except ptr and ops_done wrap.
- Simultaneous requests: resolved only by ptr order; no fixed priority other than after reset.
- Reset mid-operation (EXEC or RESP): operation discarded, no ack, ops_done not incremented, all state returns to reset values on that edge.
- res_out and ovf_out hold their last values in IDLE; consumers use them only with ack.

Test Plan:
1. Reset, then req=4'b0001, op=11, a=2'b11, b=2'b01 -> ack=4'b0001 two cycles after grant, res_out=2'b00, ovf_out=1, ops_done=1.
2. req=4'b1111, all held high, each requester i with op=00, a=2'b11, b=i -> acks in order 0,1,2,3,0, spaced 3 cycles apart; res_out=i&3.
3. After requester 2 is served, req=4'b0101 -> requester 0 is granted next (ptr=3 wraps to 0), then requester 2.
4. Requester 1 XOR, a=2'b10, b=2'b11; change a_in to 2'b00 during EXEC -> res_out=2'b01 (operands latched at grant), ovf_out=0.
5. Grant requester 3 and assert reset in EXEC -> no ack, busy=0, ops_done unchanged at 0, next req=4'b1001 grants requester 0.
6. Run 256 single-requester operations -> ops_done wraps from 8'hFF to 8'h00; OR a=01, b=10 -> res_out=11, ovf_out=0.

Source files
------------

// File: rtl/mcpu_alu_arbiter_if.sv
// Requester-side bus of the MCPU ALU arbiter: packed per-requester
// request/opcode/operand lanes in, one-hot ack plus registered result out.
interface mcpu_alu_arbiter_if #(
  parameter int CMD_SIZE  = 2,
  parameter int WORD_SIZE = 2,
  parameter int NREQ      = 4,
  parameter int CNT_SIZE  = 8
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]           req;
  logic [NREQ*CMD_SIZE-1:0]  op_in;
  logic [NREQ*WORD_SIZE-1:0] a_in;
  logic [NREQ*WORD_SIZE-1:0] b_in;
  logic [NREQ-1:0]           ack;
  logic [WORD_SIZE-1:0]      res_out;
  logic                      ovf_out;
  logic                      busy;
  logic [IDW-1:0]            grant_id;
  logic [CNT_SIZE-1:0]       ops_done;

  // Control units side
  modport master (
    output req, op_in, a_in, b_in,
    input  ack, res_out, ovf_out, busy, grant_id, ops_done
  );

  // Arbiter side
  modport slave (
    input  req, op_in, a_in, b_in,
    output ack, res_out, ovf_out, busy, grant_id, ops_done
  );
endinterface

// File: rtl/mcpu_alu_arbiter.sv
// Round-robin arbiter sharing one combinational MCPU ALU among NREQ
// requesters. Grant latches the winner's op/operands, the ALU settles for a
// full cycle, then result/overflow are registered and acked for one cycle.
module mcpu_alu_arbiter #(
  parameter int CMD_SIZE  = 2,
  parameter int WORD_SIZE = 2,
  parameter int NREQ      = 4,
  parameter int CNT_SIZE  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mcpu_alu_arbiter_if.slave    rq,
  output logic [CMD_SIZE-1:0]  alu_opcode,
  output logic [WORD_SIZE-1:0] alu_r1,
  output logic [WORD_SIZE-1:0] alu_r2,
  input  logic [WORD_SIZE-1:0] alu_out,
  input  logic                 alu_overflow
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CMD_SIZE-1:0] OP_ADD = CMD_SIZE'(3);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;

  logic [NREQ-1:0][CMD_SIZE-1:0]  op_l;
  logic [NREQ-1:0][WORD_SIZE-1:0] a_l, b_l;

  logic [IDW-1:0]       ptr, pick, gid_q;
  logic                 found;
  logic [NREQ-1:0]      ack_q;
  logic [WORD_SIZE-1:0] res_q;
  logic                 ovf_q, busy_q;
  logic [CNT_SIZE-1:0]  done_q;

  // Unpack the flat per-requester buses into lane arrays
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign op_l[i] = rq.op_in[i*CMD_SIZE  +: CMD_SIZE];
    assign a_l[i]  = rq.a_in [i*WORD_SIZE +: WORD_SIZE];
    assign b_l[i]  = rq.b_in [i*WORD_SIZE +: WORD_SIZE];
  end

  // Round-robin pick: first set req bit scanning ptr, ptr+1, ... mod NREQ
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (!found && rq.req[idx]) begin
        pick  = IDW'(idx);
        found = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: fixed three-cycle walk once a request is seen
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: grant latch, result capture, ack pulse, pointer/counter update
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      gid_q      <= '0;
      alu_opcode <= '0;
      alu_r1     <= '0;
      alu_r2     <= '0;
      ack_q      <= '0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          gid_q      <= pick;
          alu_opcode <= op_l[pick];
          alu_r1     <= a_l[pick];
          alu_r2     <= b_l[pick];
          busy_q     <= 1'b1;
        end
        EXEC: begin
          res_q <= alu_out;
          // Overflow only carries meaning for ADD; the ALU flag is ignored otherwise
          ovf_q <= (alu_opcode == OP_ADD) ? alu_overflow : 1'b0;
          ack_q <= NREQ'(1) << gid_q;
        end
        RESP: begin
          ack_q  <= '0;
          busy_q <= 1'b0;
          done_q <= done_q + CNT_SIZE'(1);
          ptr    <= (int'(gid_q) == NREQ-1) ? '0 : gid_q + IDW'(1);
        end
        default: ;
      endcase
    end
  end

  assign rq.ack      = ack_q;
  assign rq.res_out  = res_q;
  assign rq.ovf_out  = ovf_q;
  assign rq.busy     = busy_q;
  assign rq.grant_id = gid_q;
  assign rq.ops_done = done_q;
endmodule
